irst_rerand_engine: RTL and testbench

- Parametrised instruction-memory re-randomisation engine for the mips_16 core family.
- On a start pulse it stalls the pipeline and sweeps a configurable window of instruction memory. For each word it decodes with the old key, re-encodes with a new key, and writes the result back.
- It then swaps keys, releases the pipeline and pulses done.
- It generalises the fixed 16-bit in-fetch-stage rewrite path to any width, depth and window, with key rollover and error reporting.

---
 rtl/irst_rerand_engine_pkg.sv | 42 ++++
 rtl/irst_rerand_engine_if.sv | 34 +++
 rtl/irst_rerand_engine_key_mask.sv | 19 +
 rtl/irst_rerand_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_irst_rerand_engine.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irst_rerand_engine_pkg.sv
// Shared types, constants and the key-mask helper for the instruction-memory
// re-randomisation engine (package irst_pkg).
package irst_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        DRAIN = 4'd1,
        RD    = 4'd2,
        WAIT  = 4'd3,
        WR    = 4'd4,
        VRD   = 4'd5,
        VWAIT = 4'd6,
        SWAP  = 4'd7,
        FIN   = 4'd8
    } irst_state_e;

    // Cycles the fetch/decode stages need to retire after the stall is raised.
    localparam int unsigned DRAIN_CYC = 3;

    // Widest key the mask helper can rotate.
    localparam int unsigned KMAX_W = 64;

    // Rotate the low w bits of key left by (addr*rot) mod w.
    function automatic logic [KMAX_W-1:0] kmask(
        input logic [KMAX_W-1:0] key,
        input int unsigned       addr,
        input int unsigned       w,
        input int unsigned       rot
    );
        logic [KMAX_W-1:0] res;
        int unsigned       amt;
        int unsigned       dst;
        res = {KMAX_W{1'b0}};
        amt = (addr * rot) % w;
        for (int unsigned i = 0; i < w; i++) begin
            dst      = (i + amt) % w;
            res[dst] = key[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/irst_rerand_engine_if.sv
// Control and instruction-memory bus of the re-randomisation engine.
// The engine connects through the slave modport; core/memory side uses master.
interface irst_rerand_engine_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned KEY_W  = DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [KEY_W-1:0]  new_key;
    logic [KEY_W-1:0]  cur_key;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic              core_stall_n;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, length, new_key, mem_rd_data,
        input  cur_key, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  core_stall_n, busy, done, err
    );

    modport slave (
        input  start, base_addr, length, new_key, mem_rd_data,
        output cur_key, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output core_stall_n, busy, done, err
    );
endinterface

// File: rtl/irst_rerand_engine_key_mask.sv
// Combinational per-address key mask: rotl(key, (addr*ROT) mod DATA_W).
module irst_key_mask
    import irst_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned ROT    = 3
) (
    input  logic [DATA_W-1:0] key,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] mask
);

    // Mask for the addressed word.
    always_comb begin
        mask = DATA_W'(kmask(KMAX_W'(key), 32'(addr), DATA_W, ROT));
    end

endmodule

// File: rtl/irst_rerand_engine.sv
// Instruction-memory re-randomisation engine: stalls the core, re-keys a window
// of memory word by word, then swaps keys. Optional verify pass: IRST_VERIFY_EN.
module irst_rerand_engine
    import irst_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned KEY_W  = DATA_W,
    parameter int unsigned ROT    = 3
) (
    input logic                 clk,
    input logic                 rst,
    irst_rerand_engine_if.slave bus
);

    if (KEY_W != DATA_W) begin : g_key_w_chk
        $error("irst_rerand_engine: KEY_W must equal DATA_W");
    end
    if (ROT >= DATA_W) begin : g_rot_chk
        $error("irst_rerand_engine: ROT must be below DATA_W");
    end
    if (DATA_W > KMAX_W) begin : g_data_w_chk
        $error("irst_rerand_engine: DATA_W exceeds KMAX_W");
    end

    localparam logic [ADDR_W+1:0] WIN_MAX    = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   REM_ONE    = (ADDR_W+1)'(1'b1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1'b1);
    localparam logic [1:0]        DRAIN_LAST = 2'(DRAIN_CYC - 1);

    irst_state_e       state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W:0]   remaining_r;
    logic [KEY_W-1:0]  nkey_r;
    logic [KEY_W-1:0]  cur_key_r;
    logic [1:0]        drain_cnt_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              rd_en_r;
    logic              wr_en_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              stall_n_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

`ifdef IRST_VERIFY_EN
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [DATA_W-1:0] wr_xor_r;
    logic [DATA_W-1:0] rd_xor_r;
    logic              vfail_r;
`endif

    logic [DATA_W-1:0] old_mask_s;
    logic [DATA_W-1:0] new_mask_s;
    logic [ADDR_W+1:0] win_end_s;
    logic              len_over_s;
    logic              win_over_s;
    logic [ADDR_W:0]   len_eff_s;

    irst_key_mask #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROT(ROT)) u_old_mask (
        .key  (cur_key_r),
        .addr (ptr_r),
        .mask (old_mask_s)
    );

    irst_key_mask #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROT(ROT)) u_new_mask (
        .key  (nkey_r),
        .addr (ptr_r),
        .mask (new_mask_s)
    );

    // Range check of the requested window; oversize lengths clamp to the full memory.
    always_comb begin
        win_end_s  = {2'b00, bus.base_addr} + {1'b0, bus.length};
        len_over_s = ({1'b0, bus.length} > WIN_MAX);
        win_over_s = (win_end_s > WIN_MAX);
        len_eff_s  = len_over_s ? WIN_MAX[ADDR_W:0] : bus.length;
    end

    // Sweep sequencer with registered memory strobes and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= {ADDR_W{1'b0}};
            remaining_r <= {(ADDR_W+1){1'b0}};
            nkey_r      <= {KEY_W{1'b0}};
            cur_key_r   <= {KEY_W{1'b0}};
            drain_cnt_r <= 2'd0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            rd_en_r     <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_data_r   <= {DATA_W{1'b0}};
            stall_n_r   <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef IRST_VERIFY_EN
            base_r      <= {ADDR_W{1'b0}};
            len_r       <= {(ADDR_W+1){1'b0}};
            wr_xor_r    <= {DATA_W{1'b0}};
            rd_xor_r    <= {DATA_W{1'b0}};
            vfail_r     <= 1'b0;
`endif
        end else begin
            rd_en_r <= 1'b0;
            wr_en_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.length == {(ADDR_W+1){1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            ptr_r       <= bus.base_addr;
                            remaining_r <= len_eff_s;
                            nkey_r      <= bus.new_key;
                            err_r       <= len_over_s | win_over_s;
                            drain_cnt_r <= 2'd0;
                            busy_r      <= 1'b1;
                            stall_n_r   <= 1'b0;
                            state_r     <= DRAIN;
`ifdef IRST_VERIFY_EN
                            base_r      <= bus.base_addr;
                            len_r       <= len_eff_s;
                            wr_xor_r    <= {DATA_W{1'b0}};
                            rd_xor_r    <= {DATA_W{1'b0}};
                            vfail_r     <= 1'b0;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        rd_en_r    <= 1'b1;
                        mem_addr_r <= ptr_r;
                        state_r    <= RD;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                RD: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    wr_data_r  <= bus.mem_rd_data ^ old_mask_s ^ new_mask_s;
                    wr_en_r    <= 1'b1;
                    mem_addr_r <= ptr_r;
                    state_r    <= WR;
                end
                WR: begin
`ifdef IRST_VERIFY_EN
                    wr_xor_r <= wr_xor_r ^ wr_data_r;
`endif
                    if (remaining_r > REM_ONE) begin
                        ptr_r       <= ptr_r + PTR_ONE;
                        remaining_r <= remaining_r - REM_ONE;
                        rd_en_r     <= 1'b1;
                        mem_addr_r  <= ptr_r + PTR_ONE;
                        state_r     <= RD;
                    end else begin
`ifdef IRST_VERIFY_EN
                        ptr_r       <= base_r;
                        remaining_r <= len_r;
                        rd_en_r     <= 1'b1;
                        mem_addr_r  <= base_r;
                        state_r     <= VRD;
`else
                        state_r     <= SWAP;
`endif
                    end
                end
`ifdef IRST_VERIFY_EN
                VRD: begin
                    state_r <= VWAIT;
                end
                VWAIT: begin
                    rd_xor_r <= rd_xor_r ^ bus.mem_rd_data;
                    if (remaining_r > REM_ONE) begin
                        ptr_r       <= ptr_r + PTR_ONE;
                        remaining_r <= remaining_r - REM_ONE;
                        rd_en_r     <= 1'b1;
                        mem_addr_r  <= ptr_r + PTR_ONE;
                        state_r     <= VRD;
                    end else begin
                        // Read-back checksum must equal the checksum of everything written.
                        if ((rd_xor_r ^ bus.mem_rd_data) != wr_xor_r) begin
                            vfail_r <= 1'b1;
                            err_r   <= 1'b1;
                        end
                        state_r <= SWAP;
                    end
                end
`endif
                SWAP: begin
`ifdef IRST_VERIFY_EN
                    if (!vfail_r) begin
                        cur_key_r <= nkey_r;
                    end
`else
                    cur_key_r <= nkey_r;
`endif
                    state_r <= FIN;
                end
                FIN: begin
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    stall_n_r <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.cur_key      = cur_key_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_rd_en    = rd_en_r;
    assign bus.mem_wr_en    = wr_en_r;
    assign bus.mem_wr_data  = wr_data_r;
    assign bus.core_stall_n = stall_n_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.err          = err_r;

endmodule

// File: tb/tb_irst_rerand_engine.sv
// Self-checking bench for irst_rerand_engine (DATA_W=16, ADDR_W=4, ROT=3) with a
// behavioural memory and image model; covers IRST_VERIFY_EN builds as well.
module tb_irst_rerand_engine;

    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irst_rerand_engine_if #(.DATA_W(16), .ADDR_W(4), .KEY_W(16)) bus ();

    irst_rerand_engine #(.DATA_W(16), .ADDR_W(4), .KEY_W(16), .ROT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mem       [NW];
    logic [15:0] load_img  [NW];
    logic [15:0] plain     [NW];
    logic [15:0] model_mem [NW];
    logic [15:0] model_key;
    logic        load_req = 1'b0;
    logic        clr_req  = 1'b0;
    logic        fault_en = 1'b0;
    logic [15:0] wr_mask;
    int          wr_total;
    int          rd_total;
    int          both_cnt = 0;

    // Memory with one-cycle read latency, write log and optional read-back fault on word 1.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < NW; i++) mem[i] <= load_img[i];
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
        end
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= mem[bus.mem_addr] ^
                ((fault_en && bus.mem_addr == 4'd1 && wr_mask[1]) ? 16'h0100 : 16'h0000);
        end
        if (clr_req) begin
            wr_mask  <= 16'h0000;
            wr_total <= 0;
            rd_total <= 0;
        end else begin
            if (bus.mem_wr_en) begin
                wr_mask[bus.mem_addr] <= 1'b1;
                wr_total <= wr_total + 1;
            end
            if (bus.mem_rd_en) rd_total <= rd_total + 1;
        end
        if (bus.mem_rd_en && bus.mem_wr_en) both_cnt <= both_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] rotl16(input logic [15:0] k, input int n);
        logic [31:0] t;
        t = {k, k} << n;
        return t[31:16];
    endfunction

    function automatic logic [15:0] kmask16(input logic [15:0] k, input int a);
        return rotl16(k, (a * 3) % 16);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_cur_key"}, 32'(bus.cur_key), 32'h0);
        check_value({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h0);
        check_value({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'h0);
        check_value({tag, "_wr_en"}, 32'(bus.mem_wr_en), 32'h0);
        check_value({tag, "_wr_data"}, 32'(bus.mem_wr_data), 32'h0);
        check_value({tag, "_stall_n"}, 32'(bus.core_stall_n), 32'h1);
        check_value({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check_value({tag, "_done"}, 32'(bus.done), 32'h0);
        check_value({tag, "_err"}, 32'(bus.err), 32'h0);
    endtask

    task automatic do_sweep(input logic [3:0] base, input logic [4:0] len,
                            input logic [15:0] key, input string tag);
        int          leff, exp_lat, cyc, bad_stall, a;
        logic [15:0] nm [NW];
        logic [15:0] exp_mask, exp_key;
        logic        exp_err, fault_hit;
        leff      = (len > 5'd16) ? 16 : int'(len);
        exp_err   = (int'(base) + int'(len)) > 16;
        exp_mask  = 16'h0000;
        fault_hit = 1'b0;
        for (int i = 0; i < NW; i++) nm[i] = model_mem[i];
        for (int i = 0; i < leff; i++) begin
            a           = (int'(base) + i) % 16;
            exp_mask[a] = 1'b1;
            nm[a]       = model_mem[a] ^ kmask16(model_key, a) ^ kmask16(key, a);
            if (a == 1) fault_hit = fault_en;
        end
`ifdef IRST_VERIFY_EN
        exp_lat = 6 + 5 * leff;
`else
        fault_hit = 1'b0;
        exp_lat   = 6 + 3 * leff;
`endif
        if (leff == 0) exp_lat = 1;
        exp_key = (leff == 0 || fault_hit) ? model_key : key;
        exp_err = exp_err | fault_hit;

        @(posedge clk); #1;
        clr_req       = 1'b1;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = len;
        bus.new_key   = key;
        @(posedge clk); #1;
        clr_req       = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = 4'($urandom);
        bus.length    = 5'($urandom);
        bus.new_key   = 16'($urandom);
        cyc       = 1;
        bad_stall = 0;
        while (!bus.done && cyc < 200) begin
            if (bus.core_stall_n !== 1'b0 || bus.busy !== 1'b1) bad_stall++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.done) cyc = -1;
        check_value({tag, "_done_cycle"}, 32'(cyc), 32'(exp_lat));
        check_value({tag, "_stall_during"}, 32'(bad_stall), 32'h0);
        check_value({tag, "_stall_n_at_done"}, 32'(bus.core_stall_n), 32'h1);
        check_value({tag, "_busy_at_done"}, 32'(bus.busy), 32'h0);
        check_value({tag, "_cur_key"}, 32'(bus.cur_key), 32'(exp_key));
        if (leff != 0) check_value({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check_value({tag, "_wr_mask"}, 32'(wr_mask), 32'(exp_mask));
        check_value({tag, "_wr_total"}, 32'(wr_total), 32'(leff));
`ifdef IRST_VERIFY_EN
        check_value({tag, "_rd_total"}, 32'(rd_total), 32'(2 * leff));
`else
        check_value({tag, "_rd_total"}, 32'(rd_total), 32'(leff));
`endif
        for (int i = 0; i < NW; i++)
            check_value($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(nm[i]));
        @(posedge clk); #1;
        check_value({tag, "_done_pulse"}, 32'(bus.done), 32'h0);
        for (int i = 0; i < NW; i++) model_mem[i] = nm[i];
        model_key = exp_key;
    endtask

    initial begin
        int          cnt;
        logic [3:0]  rb;
        logic [4:0]  rl;
        int          r;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = 4'd0;
        bus.length    = 5'd0;
        bus.new_key   = 16'h0000;
        for (int i = 0; i < NW; i++) begin
            plain[i]     = 16'($urandom);
            load_img[i]  = plain[i];
            model_mem[i] = plain[i];
        end
        model_key = 16'h0000;
        load_req  = 1'b1;
        clr_req   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        load_req = 1'b0;
        clr_req  = 1'b0;
        check_reset_outputs("reset");

        do_sweep(4'd0, 5'd4, 16'hA5A5, "key_a5a5");
        for (int i = 0; i < 4; i++)
            check_value($sformatf("a5a5_enc%0d", i), 32'(mem[i]),
                        32'(plain[i] ^ rotl16(16'hA5A5, 3 * i)));

        do_sweep(4'd0, 5'd4, 16'h1234, "key_1234");
        for (int i = 0; i < 4; i++)
            check_value($sformatf("k1234_dec%0d", i), 32'(mem[i] ^ kmask16(16'h1234, i)),
                        32'(plain[i]));

        do_sweep(4'd7, 5'd0, 16'hBEEF, "len0");
        do_sweep(4'd14, 5'd4, 16'h0F1E, "wrap");

        // Reset during the write of word 2.
        @(posedge clk); #1;
        clr_req       = 1'b1;
        bus.start     = 1'b1;
        bus.base_addr = 4'd0;
        bus.length    = 5'd4;
        bus.new_key   = 16'h0F0F;
        @(posedge clk); #1;
        clr_req   = 1'b0;
        bus.start = 1'b0;
        cnt = 0;
        while (!(bus.mem_wr_en && bus.mem_addr == 4'd2) && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_value("rst_wr2_reached", 32'(cnt < 100), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        check_value("midrst_wr_mask", 32'(wr_mask), 32'h0003);
        check_value("midrst_mem0", 32'(mem[0]),
                    32'(model_mem[0] ^ kmask16(model_key, 0) ^ kmask16(16'h0F0F, 0)));
        check_value("midrst_mem2", 32'(mem[2]), 32'(model_mem[2]));
        for (int i = 0; i < NW; i++) begin
            load_img[i]  = plain[i];
            model_mem[i] = plain[i];
        end
        model_key = 16'h0000;
        load_req  = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        do_sweep(4'd0, 5'd4, 16'h5A5A, "after_rst");

        for (int n = 0; n < 24; n++) begin
            rb = 4'($urandom_range(0, 15));
            r  = int'($urandom_range(0, 9));
            if (r == 0) rl = 5'd0;
            else if (r == 1) rl = 5'($urandom_range(17, 31));
            else rl = 5'($urandom_range(1, 16));
            do_sweep(rb, rl, 16'($urandom), $sformatf("rnd%0d", n));
        end

`ifdef IRST_VERIFY_EN
        fault_en = 1'b1;
        do_sweep(4'd0, 5'd4, 16'hC3C3, "vfault");
        fault_en = 1'b0;
`endif

        check_value("rd_wr_overlap", 32'(both_cnt), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
